// File: rtl/noc_flit_depacketizer_pkg.sv
// Shared widths, flit field layout, framing markers and error codes for the
// NoC ejection path (flit depacketizer and its payload FIFO).
package noc_flit_depacketizer_pkg;

    localparam int NOC_DATA_W  = 64;
    localparam int NOC_ID_X_W  = 4;
    localparam int NOC_ID_Y_W  = 4;
    localparam int AXI_TYPE_W  = 2;
    localparam int AXI_ORDER_W = 4;
    localparam int AXI_LEN_W   = 4;
    localparam int MARK_W      = 4;

    localparam logic [MARK_W-1:0] HEAD_H = 4'hA;
    localparam logic [MARK_W-1:0] HEAD_E = 4'h5;
    localparam logic [MARK_W-1:0] TAIL_H = 4'hC;
    localparam logic [MARK_W-1:0] TAIL_E = 4'h3;

    // Field LSB positions inside a header/tail flit; the low bits below MARK_E are padding.
    localparam int MARK_H_POINT    = 60;
    localparam int SRC_X_POINT     = 56;
    localparam int SRC_Y_POINT     = 52;
    localparam int NOC_DEST_POINT  = 48;
    localparam int DST_Y_POINT     = 44;
    localparam int AXI_TYPE_POINT  = 42;
    localparam int AXI_ORDER_POINT = 38;
    localparam int AXI_LEN_POINT   = 34;
    localparam int MARK_E_POINT    = 30;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_FRAME = 3'd1;
    localparam logic [2:0] ERR_DEST  = 3'd2;
    localparam logic [2:0] ERR_SHORT = 3'd3;
    localparam logic [2:0] ERR_LONG  = 3'd4;
    localparam logic [2:0] ERR_TAIL  = 3'd5;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2,
        ST_DROP = 2'd3
    } depkt_state_e;

    typedef struct packed {
        logic [MARK_W-1:0]      mark_h;
        logic [NOC_ID_X_W-1:0]  src_x;
        logic [NOC_ID_Y_W-1:0]  src_y;
        logic [NOC_ID_X_W-1:0]  dst_x;
        logic [NOC_ID_Y_W-1:0]  dst_y;
        logic [AXI_TYPE_W-1:0]  pkt_type;
        logic [AXI_ORDER_W-1:0] order;
        logic [AXI_LEN_W-1:0]   len;
        logic [MARK_W-1:0]      mark_e;
    } flit_fields_t;

    localparam int FIELDS_W = $bits(flit_fields_t);

endpackage

// File: rtl/noc_flit_depacketizer_fifo.sv
// Synchronous FIFO with flop-based storage and full/empty flags; the head entry
// is read straight from the storage flops so a push is visible the next cycle.
module noc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             noc_clk,
    input  logic             noc_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/noc_flit_depacketizer.sv
// Ejection stage: validates header/tail framing and destination, extracts header
// fields, streams payload flits through a FIFO and reports one error per packet.
module noc_flit_depacketizer
    import noc_flit_depacketizer_pkg::*;
#(
    parameter logic [NOC_ID_X_W-1:0] X_ID       = '0,
    parameter logic [NOC_ID_Y_W-1:0] Y_ID       = '0,
    parameter int                    FIFO_DEPTH = 8
) (
    input  logic                   noc_clk,
    input  logic                   noc_rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NOC_DATA_W-1:0]  in_flit,
    input  logic                   in_is_header,
    input  logic                   in_is_tail,
    output logic                   pkt_start,
    output logic [NOC_ID_X_W-1:0]  pkt_src_x,
    output logic [NOC_ID_Y_W-1:0]  pkt_src_y,
    output logic [AXI_TYPE_W-1:0]  pkt_type,
    output logic [AXI_ORDER_W-1:0] pkt_order,
    output logic [AXI_LEN_W-1:0]   pkt_len,
    output logic                   pl_valid,
    input  logic                   pl_ready,
    output logic [NOC_DATA_W-1:0]  pl_data,
    output logic                   pl_last,
    output logic                   err_pulse,
    output logic [2:0]             err_code,
    output logic [15:0]            pkt_count
);

    depkt_state_e           state_q, state_d;
    logic [AXI_LEN_W-1:0]   cnt_q, cnt_d;
    logic [NOC_ID_X_W-1:0]  src_x_q, src_x_d;
    logic [NOC_ID_Y_W-1:0]  src_y_q, src_y_d;
    logic [AXI_TYPE_W-1:0]  type_q, type_d;
    logic [AXI_ORDER_W-1:0] order_q, order_d;
    logic [AXI_LEN_W-1:0]   len_q, len_d;
    logic                   pkt_start_q, pkt_start_d;
    logic                   err_pulse_q, err_pulse_d;
    logic [2:0]             err_code_q, err_code_d;
    logic [15:0]            pkt_count_q, pkt_count_d;

    flit_fields_t           fields;
    logic                   accept, both_flags;
    logic                   head_marks_ok, tail_marks_ok, dst_ok, src_ok;
    logic                   raise_err;
    logic [2:0]             err_sel;
    logic                   fifo_push, fifo_full, fifo_empty;
    logic [NOC_DATA_W:0]    fifo_rdata;

    assign fields        = flit_fields_t'(in_flit[NOC_DATA_W-1 -: FIELDS_W]);
    assign accept        = in_valid && in_ready;
    assign both_flags    = in_is_header && in_is_tail;
    assign head_marks_ok = (fields.mark_h == HEAD_H) && (fields.mark_e == HEAD_E);
    assign tail_marks_ok = (fields.mark_h == TAIL_H) && (fields.mark_e == TAIL_E);
    assign dst_ok        = (fields.dst_x == X_ID) && (fields.dst_y == Y_ID);
    assign src_ok        = (fields.src_x == src_x_q) && (fields.src_y == src_y_q);

    // A flit flagged both header and tail is a framing error that also ends the packet.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_x_d     = src_x_q;
        src_y_d     = src_y_q;
        type_d      = type_q;
        order_d     = order_q;
        len_d       = len_q;
        pkt_start_d = 1'b0;
        pkt_count_d = pkt_count_q;
        in_ready    = 1'b1;
        fifo_push   = 1'b0;
        raise_err   = 1'b0;
        err_sel     = ERR_NONE;

        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    if (both_flags) begin
                        raise_err = 1'b1;
                        err_sel   = ERR_FRAME;
                    end else if (!in_is_header || !head_marks_ok) begin
                        raise_err = 1'b1;
                        err_sel   = ERR_FRAME;
                        state_d   = in_is_tail ? ST_HDR : ST_DROP;
                    end else if (!dst_ok) begin
                        raise_err = 1'b1;
                        err_sel   = ERR_DEST;
                        state_d   = ST_DROP;
                    end else begin
                        src_x_d     = fields.src_x;
                        src_y_d     = fields.src_y;
                        type_d      = fields.pkt_type;
                        order_d     = fields.order;
                        len_d       = fields.len;
                        pkt_start_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                in_ready = !fifo_full;
                if (accept) begin
                    if (both_flags) begin
                        raise_err = 1'b1;
                        err_sel   = ERR_FRAME;
                        state_d   = ST_HDR;
                    end else if (in_is_tail) begin
                        raise_err = 1'b1;
                        err_sel   = ERR_SHORT;
                        state_d   = ST_HDR;
                    end else begin
                        fifo_push = 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                        if (cnt_q == len_q) begin
                            state_d = ST_TAIL;
                        end
                    end
                end
            end
            ST_TAIL: begin
                if (accept) begin
                    if (both_flags) begin
                        raise_err = 1'b1;
                        err_sel   = ERR_FRAME;
                        state_d   = ST_HDR;
                    end else if (in_is_tail) begin
                        if (tail_marks_ok && src_ok && dst_ok) begin
                            pkt_count_d = pkt_count_q + 16'd1;
                        end else begin
                            raise_err = 1'b1;
                            err_sel   = ERR_TAIL;
                        end
                        state_d = ST_HDR;
                    end else begin
                        raise_err = 1'b1;
                        err_sel   = ERR_LONG;
                        state_d   = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (accept) begin
                    if (both_flags) begin
                        raise_err = 1'b1;
                        err_sel   = ERR_FRAME;
                    end
                    if (in_is_tail) begin
                        state_d = ST_HDR;
                    end
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase

        err_pulse_d = raise_err;
        err_code_d  = raise_err ? err_sel : err_code_q;
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q     <= ST_HDR;
            cnt_q       <= '0;
            src_x_q     <= '0;
            src_y_q     <= '0;
            type_q      <= '0;
            order_q     <= '0;
            len_q       <= '0;
            pkt_start_q <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_x_q     <= src_x_d;
            src_y_q     <= src_y_d;
            type_q      <= type_d;
            order_q     <= order_d;
            len_q       <= len_d;
            pkt_start_q <= pkt_start_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Each entry carries its last flag in bit 0 beside the payload.
    noc_sync_fifo #(
        .WIDTH (NOC_DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_payload_fifo (
        .noc_clk   (noc_clk),
        .noc_rst_n (noc_rst_n),
        .push      (fifo_push),
        .wdata     ({in_flit, (cnt_q == len_q)}),
        .pop       (pl_ready),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pl_valid  = !fifo_empty;
    assign pl_data   = fifo_rdata[NOC_DATA_W:1];
    assign pl_last   = fifo_rdata[0];
    assign pkt_start = pkt_start_q;
    assign pkt_src_x = src_x_q;
    assign pkt_src_y = src_y_q;
    assign pkt_type  = type_q;
    assign pkt_order = order_q;
    assign pkt_len   = len_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_noc_flit_depacketizer.sv
// Scoreboard bench for noc_flit_depacketizer: directed packets push expected
// beats, header events and error codes; monitors pop and compare as they appear.
module tb_noc_flit_depacketizer;

    localparam logic [3:0] MY_X = 4'd2;
    localparam logic [3:0] MY_Y = 4'd1;

    logic        noc_clk = 1'b0;
    logic        noc_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_flit = '0;
    logic        in_is_header = 1'b0;
    logic        in_is_tail = 1'b0;
    logic        pkt_start;
    logic [3:0]  pkt_src_x;
    logic [3:0]  pkt_src_y;
    logic [1:0]  pkt_type;
    logic [3:0]  pkt_order;
    logic [3:0]  pkt_len;
    logic        pl_valid;
    logic        pl_ready = 1'b1;
    logic [63:0] pl_data;
    logic        pl_last;
    logic        err_pulse;
    logic [2:0]  err_code;
    logic [15:0] pkt_count;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [3:0] sx;
        logic [3:0] sy;
        logic [1:0] ty;
        logic [3:0] ord;
        logic [3:0] len;
    } hdr_t;

    beat_t       exp_beats[$];
    hdr_t        exp_hdrs[$];
    logic [2:0]  exp_errs[$];
    int          n_checks = 0;
    int          n_fail = 0;

    noc_flit_depacketizer #(
        .X_ID       (MY_X),
        .Y_ID       (MY_Y),
        .FIFO_DEPTH (2)
    ) dut (
        .noc_clk      (noc_clk),
        .noc_rst_n    (noc_rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_flit      (in_flit),
        .in_is_header (in_is_header),
        .in_is_tail   (in_is_tail),
        .pkt_start    (pkt_start),
        .pkt_src_x    (pkt_src_x),
        .pkt_src_y    (pkt_src_y),
        .pkt_type     (pkt_type),
        .pkt_order    (pkt_order),
        .pkt_len      (pkt_len),
        .pl_valid     (pl_valid),
        .pl_ready     (pl_ready),
        .pl_data      (pl_data),
        .pl_last      (pl_last),
        .err_pulse    (err_pulse),
        .err_code     (err_code),
        .pkt_count    (pkt_count)
    );

    always #5 noc_clk = ~noc_clk;

    function automatic logic [63:0] mk_flit(input logic [3:0] mh, input logic [3:0] sx,
                                            input logic [3:0] sy, input logic [3:0] dx,
                                            input logic [3:0] dy, input logic [1:0] ty,
                                            input logic [3:0] ord, input logic [3:0] len,
                                            input logic [3:0] me);
        return {mh, sx, sy, dx, dy, ty, ord, len, me, 30'h0};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge noc_clk);
    endtask

    // Drive one flit from a negedge and hold it until accepted, bounded by a cycle budget.
    task automatic applyStimulus(input logic [63:0] flit, input logic hdr, input logic tl);
        bit done;
        int waited;
        in_flit      = flit;
        in_is_header = hdr;
        in_is_tail   = tl;
        in_valid     = 1'b1;
        done         = 1'b0;
        waited       = 0;
        while (!done) begin
            done = in_ready;
            @(negedge noc_clk);
            if (!done) begin
                waited++;
                if (waited >= 100) begin
                    checkOutput("flit_accept_timeout", 64'(waited), 64'd0);
                    done = 1'b1;
                end
            end
        end
        in_valid     = 1'b0;
        in_is_header = 1'b0;
        in_is_tail   = 1'b0;
    endtask

    task automatic send_hdr(input logic [3:0] sx, input logic [3:0] sy, input logic [3:0] dx,
                            input logic [3:0] dy, input logic [1:0] ty, input logic [3:0] ord,
                            input logic [3:0] len, input bit expect_start);
        hdr_t h;
        if (expect_start) begin
            h.sx = sx; h.sy = sy; h.ty = ty; h.ord = ord; h.len = len;
            exp_hdrs.push_back(h);
        end
        applyStimulus(mk_flit(4'hA, sx, sy, dx, dy, ty, ord, len, 4'h5), 1'b1, 1'b0);
    endtask

    task automatic send_data(input logic [63:0] d, input bit expect_beat, input logic last);
        beat_t b;
        if (expect_beat) begin
            b.data = d;
            b.last = last;
            exp_beats.push_back(b);
        end
        applyStimulus(d, 1'b0, 1'b0);
    endtask

    task automatic send_tail(input logic [3:0] mh, input logic [3:0] sx, input logic [3:0] sy,
                             input logic [3:0] me);
        applyStimulus(mk_flit(mh, sx, sy, MY_X, MY_Y, 2'd0, 4'd0, 4'd0, me), 1'b0, 1'b1);
    endtask

    // Monitor: compares every handshaken beat, header event and error pulse against the queues.
    initial begin
        beat_t      b;
        hdr_t       h;
        logic [2:0] e;
        forever begin
            @(negedge noc_clk);
            #2;
            if (noc_rst_n) begin
                if (pl_valid && pl_ready) begin
                    if (exp_beats.size() == 0) begin
                        checkOutput("unexpected_beat", pl_data, 64'd0);
                        if (pl_data == 64'd0) checkOutput("unexpected_beat_valid", 64'(pl_valid), 64'd0);
                    end else begin
                        b = exp_beats.pop_front();
                        checkOutput("pl_data", pl_data, b.data);
                        checkOutput("pl_last", 64'(pl_last), 64'(b.last));
                    end
                end
                if (pkt_start) begin
                    if (exp_hdrs.size() == 0) begin
                        checkOutput("unexpected_pkt_start", 64'(pkt_start), 64'd0);
                    end else begin
                        h = exp_hdrs.pop_front();
                        checkOutput("pkt_src_x", 64'(pkt_src_x), 64'(h.sx));
                        checkOutput("pkt_src_y", 64'(pkt_src_y), 64'(h.sy));
                        checkOutput("pkt_type", 64'(pkt_type), 64'(h.ty));
                        checkOutput("pkt_order", 64'(pkt_order), 64'(h.ord));
                        checkOutput("pkt_len", 64'(pkt_len), 64'(h.len));
                    end
                end
                if (err_pulse) begin
                    if (exp_errs.size() == 0) begin
                        checkOutput("unexpected_err_pulse", 64'(err_code), 64'hEE);
                    end else begin
                        e = exp_errs.pop_front();
                        checkOutput("err_code", 64'(err_code), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        idle(2);
        checkOutput("rst_pkt_start", 64'(pkt_start), 64'd0);
        checkOutput("rst_pl_valid", 64'(pl_valid), 64'd0);
        checkOutput("rst_pl_data", pl_data, 64'd0);
        checkOutput("rst_pl_last", 64'(pl_last), 64'd0);
        checkOutput("rst_err_pulse", 64'(err_pulse), 64'd0);
        checkOutput("rst_err_code", 64'(err_code), 64'd0);
        checkOutput("rst_pkt_count", 64'(pkt_count), 64'd0);
        checkOutput("rst_pkt_fields", 64'({pkt_src_x, pkt_src_y, pkt_type, pkt_order, pkt_len}), 64'd0);
        noc_rst_n = 1'b1;
        idle(1);

        // 1: single-beat packet of all ones
        send_hdr(4'd3, 4'd2, MY_X, MY_Y, 2'd1, 4'd5, 4'd0, 1'b1);
        send_data(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        send_tail(4'hC, 4'd3, 4'd2, 4'h3);
        idle(3);
        checkOutput("t1_pkt_count", 64'(pkt_count), 64'd1);

        // 2: backpressure with a two-entry FIFO
        pl_ready = 1'b0;
        send_hdr(4'd1, 4'd0, MY_X, MY_Y, 2'd2, 4'd1, 4'd3, 1'b1);
        send_data(64'd1, 1'b1, 1'b0);
        send_data(64'd2, 1'b1, 1'b0);
        checkOutput("t2_in_ready_full", 64'(in_ready), 64'd0);
        idle(3);
        checkOutput("t2_in_ready_held", 64'(in_ready), 64'd0);
        checkOutput("t2_pl_valid_held", 64'(pl_valid), 64'd1);
        pl_ready = 1'b1;
        send_data(64'd3, 1'b1, 1'b0);
        send_data(64'd4, 1'b1, 1'b1);
        send_tail(4'hC, 4'd1, 4'd0, 4'h3);
        idle(3);
        checkOutput("t2_pkt_count", 64'(pkt_count), 64'd2);

        // 3: misrouted packet, then a good one
        exp_errs.push_back(3'd2);
        send_hdr(4'd1, 4'd1, MY_X + 4'd1, MY_Y, 2'd0, 4'd0, 4'd1, 1'b0);
        send_data(64'hDEAD, 1'b0, 1'b0);
        send_data(64'hBEEF, 1'b0, 1'b0);
        send_tail(4'hC, 4'd1, 4'd1, 4'h3);
        idle(2);
        checkOutput("t3_err_code_hold", 64'(err_code), 64'd2);
        send_hdr(4'd0, 4'd3, MY_X, MY_Y, 2'd0, 4'd2, 4'd1, 1'b1);
        send_data(64'h11, 1'b1, 1'b0);
        send_data(64'h22, 1'b1, 1'b1);
        send_tail(4'hC, 4'd0, 4'd3, 4'h3);
        idle(3);
        checkOutput("t3_pkt_count", 64'(pkt_count), 64'd3);

        // 4: tail arrives early
        exp_errs.push_back(3'd3);
        send_hdr(4'd2, 4'd2, MY_X, MY_Y, 2'd3, 4'd7, 4'd2, 1'b1);
        send_data(64'hAB, 1'b1, 1'b0);
        send_tail(4'hC, 4'd2, 4'd2, 4'h3);
        idle(3);
        checkOutput("t4_in_ready_hdr", 64'(in_ready), 64'd1);
        checkOutput("t4_pkt_count", 64'(pkt_count), 64'd3);

        // 5: stray data flit in HDR, then a both-flags flit, then a good packet
        exp_errs.push_back(3'd1);
        send_data(64'h1234, 1'b0, 1'b0);
        send_data(64'h5678, 1'b0, 1'b0);
        send_tail(4'hC, 4'd0, 4'd0, 4'h3);
        idle(2);
        checkOutput("t5_err_code", 64'(err_code), 64'd1);
        exp_errs.push_back(3'd1);
        applyStimulus(mk_flit(4'hA, 4'd1, 4'd1, MY_X, MY_Y, 2'd0, 4'd0, 4'd0, 4'h5), 1'b1, 1'b1);
        idle(2);
        send_hdr(4'd1, 4'd2, MY_X, MY_Y, 2'd1, 4'd3, 4'd0, 1'b1);
        send_data(64'h55, 1'b1, 1'b1);
        send_tail(4'hC, 4'd1, 4'd2, 4'h3);
        idle(3);
        checkOutput("t5_pkt_count", 64'(pkt_count), 64'd4);

        // 7: extra data flit where the tail belongs
        exp_errs.push_back(3'd4);
        send_hdr(4'd1, 4'd1, MY_X, MY_Y, 2'd0, 4'd0, 4'd0, 1'b1);
        send_data(64'h77, 1'b1, 1'b1);
        send_data(64'h78, 1'b0, 1'b0);
        send_tail(4'hC, 4'd1, 4'd1, 4'h3);
        idle(3);
        checkOutput("t7_err_code", 64'(err_code), 64'd4);

        // 8: tail whose source does not match the header
        exp_errs.push_back(3'd5);
        send_hdr(4'd1, 4'd1, MY_X, MY_Y, 2'd0, 4'd0, 4'd0, 1'b1);
        send_data(64'h88, 1'b1, 1'b1);
        send_tail(4'hC, 4'd0, 4'd1, 4'h3);
        idle(3);
        checkOutput("t8_err_code", 64'(err_code), 64'd5);
        checkOutput("t8_pkt_count", 64'(pkt_count), 64'd4);

        // 6: reset in the middle of a packet
        pl_ready = 1'b0;
        send_hdr(4'd3, 4'd3, MY_X, MY_Y, 2'd2, 4'd9, 4'd3, 1'b1);
        send_data(64'hA1, 1'b0, 1'b0);
        send_data(64'hA2, 1'b0, 1'b0);
        checkOutput("t6_pl_valid_pre", 64'(pl_valid), 64'd1);
        noc_rst_n = 1'b0;
        #1;
        checkOutput("t6_pl_valid", 64'(pl_valid), 64'd0);
        checkOutput("t6_pl_data", pl_data, 64'd0);
        checkOutput("t6_pkt_count", 64'(pkt_count), 64'd0);
        checkOutput("t6_err_code", 64'(err_code), 64'd0);
        checkOutput("t6_fields", 64'({pkt_src_x, pkt_src_y, pkt_type, pkt_order, pkt_len}), 64'd0);
        idle(2);
        noc_rst_n = 1'b1;
        pl_ready  = 1'b1;
        idle(1);
        send_hdr(4'd0, 4'd1, MY_X, MY_Y, 2'd1, 4'd2, 4'd0, 1'b1);
        send_data(64'h66, 1'b1, 1'b1);
        send_tail(4'hC, 4'd0, 4'd1, 4'h3);
        idle(4);
        checkOutput("t6_pkt_count_after", 64'(pkt_count), 64'd1);

        checkOutput("beats_left", 64'(exp_beats.size()), 64'd0);
        checkOutput("hdrs_left", 64'(exp_hdrs.size()), 64'd0);
        checkOutput("errs_left", 64'(exp_errs.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
